fp_add_pipe: RTL

FP_ADD_PIPE -- requirements
Module: fp_add_pipe

---
 rtl/fp_pkg.sv | 48 ++++
 rtl/fp_lzc.sv | 23 ++
 rtl/fp_add_pipe.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fp_pkg.sv
// -----------------------------------------------------------------------------
// fp_pkg
// Definitions shared by the pipelined floating-point adder:
//   - bit positions inside the 4-bit flags vector {invalid, overflow,
//     underflow, inexact}
//   - the operand classification enum and a width-agnostic classifier
//   - construction of the canonical quiet NaN for any exponent/mantissa width
// -----------------------------------------------------------------------------
package fp_pkg;

   localparam int FLAG_INVALID   = 3;
   localparam int FLAG_OVERFLOW  = 2;
   localparam int FLAG_UNDERFLOW = 1;
   localparam int FLAG_INEXACT   = 0;

   // Widest format fp_qnan can build; callers slice off the low W bits.
   localparam int FP_MAX_W = 128;

   typedef enum logic [1:0] {
      FP_ZERO   = 2'd0,
      FP_NORMAL = 2'd1,
      FP_INF    = 2'd2,
      FP_NAN    = 2'd3
   } fp_class_e;

   // Denormals (exponent 0) classify as zero: they are flushed on input.
   function automatic fp_class_e fp_classify(input logic exp_zero,
                                             input logic exp_ones,
                                             input logic man_zero);
      fp_class_e c;
      if (exp_zero)      c = FP_ZERO;
      else if (!exp_ones) c = FP_NORMAL;
      else if (man_zero)  c = FP_INF;
      else                c = FP_NAN;
      return c;
   endfunction

   // Canonical qNaN: sign 0, exponent all ones, only the mantissa MSB set.
   function automatic logic [FP_MAX_W-1:0] fp_qnan(input int exp_w, input int man_w);
      logic [FP_MAX_W-1:0] r;
      r = '0;
      for (int i = 0; i < FP_MAX_W; i++) begin
         if (i >= man_w - 1 && i < man_w + exp_w) r[i] = 1'b1;
      end
      return r;
   endfunction

endpackage

// File: rtl/fp_lzc.sv
// -----------------------------------------------------------------------------
// fp_lzc
// Purely combinational leading-zero counter.
//   i_data  [WIDTH-1:0] : value to scan from the MSB
//   o_count [CNT_W-1:0] : number of zeros above the first 1 (WIDTH when zero)
// -----------------------------------------------------------------------------
module fp_lzc #(
   parameter  int WIDTH = 8,
   localparam int CNT_W = $clog2(WIDTH + 1)
) (
   input  logic [WIDTH-1:0] i_data,
   output logic [CNT_W-1:0] o_count
);

   // Scan upward; the highest set bit is the last one to write the count.
   always_comb begin
      o_count = CNT_W'(WIDTH);
      for (int i = 0; i < WIDTH; i++) begin
         if (i_data[i]) o_count = CNT_W'(WIDTH - 1 - i);
      end
   end

endmodule

// File: rtl/fp_add_pipe.sv
// -----------------------------------------------------------------------------
// fp_add_pipe
// Five-stage pipelined IEEE-754-style adder, round-to-nearest-even, denormals
// flushed to zero on input and output.
//   clk, reset      : rising-edge clock, asynchronous active-low reset
//   in_valid/ready  : operation handshake for a, b, in_tag
//   out_valid/ready : result handshake for sum, out_tag, flags
//   flags           : {invalid, overflow, underflow, inexact}
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
// 1. The whole pipe moves as one: advance = !out_valid || out_ready, every
// stage loads only on advance, and in_ready = advance. While out_valid=1 and
// out_ready=0 every stage, including the outputs, holds its value.
//
// Stages: S1 classify/swap, S2 align, S3 add/sub, S4 normalise, S5 round/pack.
// -----------------------------------------------------------------------------
module fp_add_pipe
   import fp_pkg::*;
#(
   parameter  int EXP_W = 8,
   parameter  int MAN_W = 23,
   parameter  int TAG_W = 4,
   localparam int W     = 1 + EXP_W + MAN_W,
   localparam int BIAS  = (1 << (EXP_W - 1)) - 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [W-1:0]     a,
   input  logic [W-1:0]     b,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [W-1:0]     sum,
   output logic [TAG_W-1:0] out_tag,
   output logic [3:0]       flags
);

   localparam int M    = MAN_W + 1;   // mantissa with hidden bit
   localparam int E    = MAN_W + 4;   // mantissa + guard/round/sticky
   localparam int XW   = EXP_W + 2;   // exponent with headroom and sign
   localparam int LZ_W = $clog2(E + 1);
   localparam logic [EXP_W-1:0] SHIFT_CAP = EXP_W'(MAN_W + 3);
   localparam logic [XW-1:0]    EXP_ONES  = XW'(2 * BIAS + 1);

   logic w_adv;
   assign w_adv    = !out_valid || out_ready;
   assign in_ready = w_adv;

   // ---------------- S1: classify, special cases, swap ----------------------
   logic [FP_MAX_W-1:0] w_qnan_wide;
   logic [W-1:0]        w_qnan;
   fp_class_e           w_ca, w_cb;
   logic [W-2:0]        w_ka, w_kb, w_big_k, w_sml_k;
   logic                w_swap, w_big_s;
   logic [EXP_W-1:0]    w_big_e, w_sml_e;
   logic [M-1:0]        w_ma, w_mb;
   logic                w_special;
   logic [W-1:0]        w_spec_val;
   logic [3:0]          w_spec_flags;

   assign w_qnan_wide = fp_qnan(EXP_W, MAN_W);
   assign w_qnan      = w_qnan_wide[W-1:0];
   assign w_ca = fp_classify(a[W-2:MAN_W] == '0, &a[W-2:MAN_W], a[MAN_W-1:0] == '0);
   assign w_cb = fp_classify(b[W-2:MAN_W] == '0, &b[W-2:MAN_W], b[MAN_W-1:0] == '0);

   always_comb begin
      // Magnitude keys {exp, man}; flushed zeros compare as 0.
      w_ka    = (w_ca == FP_ZERO) ? '0 : a[W-2:0];
      w_kb    = (w_cb == FP_ZERO) ? '0 : b[W-2:0];
      w_swap  = (w_kb > w_ka);
      w_big_k = w_swap ? w_kb : w_ka;
      w_sml_k = w_swap ? w_ka : w_kb;
      w_big_s = w_swap ? b[W-1] : a[W-1];
      w_big_e = w_big_k[W-2:MAN_W];
      w_sml_e = w_sml_k[W-2:MAN_W];
      w_ma    = {w_big_e != '0, w_big_k[MAN_W-1:0]};
      w_mb    = {w_sml_e != '0, w_sml_k[MAN_W-1:0]};

      w_special    = 1'b0;
      w_spec_val   = '0;
      w_spec_flags = '0;
      if (w_ca == FP_NAN || w_cb == FP_NAN) begin
         w_special  = 1'b1;
         w_spec_val = w_qnan;
      end else if (w_ca == FP_INF && w_cb == FP_INF && a[W-1] != b[W-1]) begin
         w_special    = 1'b1;
         w_spec_val   = w_qnan;
         w_spec_flags[FLAG_INVALID] = 1'b1;
      end else if (w_ca == FP_INF) begin
         w_special  = 1'b1;
         w_spec_val = a;
      end else if (w_cb == FP_INF) begin
         w_special  = 1'b1;
         w_spec_val = b;
      end else if (w_ca == FP_ZERO && w_cb == FP_ZERO) begin
         // Only -0 + -0 keeps the minus sign.
         w_special  = 1'b1;
         w_spec_val = {a[W-1] & b[W-1], {(W-1){1'b0}}};
      end
   end

   // ---------------- S2: align the smaller operand --------------------------
   logic                r1_special, r1_sign, r1_sub;
   logic [W-1:0]        r1_spec_val;
   logic [3:0]          r1_spec_flags;
   logic [EXP_W-1:0]    r1_exp, r1_diff;
   logic [M-1:0]        r1_ma, r1_mb;
   logic [TAG_W-1:0]    r1_tag;
   logic [E-1:0]        w_b_ext, w_b_shr, w_b_mask, w_b_al;
   logic                w_sticky;

   always_comb begin
      w_b_ext  = {r1_mb, 3'b000};
      w_b_shr  = w_b_ext >> r1_diff;
      w_b_mask = ~({E{1'b1}} << r1_diff);
      w_sticky = |(w_b_ext & w_b_mask);
      if (r1_diff >= SHIFT_CAP) w_b_al = {{(E-1){1'b0}}, |r1_mb};
      else                      w_b_al = {w_b_shr[E-1:1], w_b_shr[0] | w_sticky};
   end

   // ---------------- S3: add / subtract magnitudes --------------------------
   logic                r2_special, r2_sign, r2_sub;
   logic [W-1:0]        r2_spec_val;
   logic [3:0]          r2_spec_flags;
   logic [EXP_W-1:0]    r2_exp;
   logic [E-1:0]        r2_ma, r2_mb;
   logic [TAG_W-1:0]    r2_tag;
   logic [E:0]          w_mag;

   // |A| >= |B| so the difference never goes negative.
   assign w_mag = r2_sub ? ({1'b0, r2_ma} - {1'b0, r2_mb})
                         : ({1'b0, r2_ma} + {1'b0, r2_mb});

   // ---------------- S4: normalise -----------------------------------------
   logic                r3_special, r3_sign;
   logic [W-1:0]        r3_spec_val;
   logic [3:0]          r3_spec_flags;
   logic [EXP_W-1:0]    r3_exp;
   logic [E:0]          r3_mag;
   logic [TAG_W-1:0]    r3_tag;
   logic [LZ_W-1:0]     w_lz;
   logic [E-1:0]        w_norm;
   logic [XW-1:0]       w_exp4;

   fp_lzc #(.WIDTH(E)) u_lzc (
      .i_data  (r3_mag[E-1:0]),
      .o_count (w_lz)
   );

   always_comb begin
      if (r3_mag[E]) begin
         // Carry out: shift right one, keep the lost bit in sticky.
         w_norm = {r3_mag[E:2], r3_mag[1] | r3_mag[0]};
         w_exp4 = {2'b00, r3_exp} + XW'(1);
      end else begin
         w_norm = r3_mag[E-1:0] << w_lz;
         w_exp4 = {2'b00, r3_exp} - {{(XW-LZ_W){1'b0}}, w_lz};
      end
   end

   // ---------------- S5: round to nearest even and pack ---------------------
   logic                r4_special, r4_sign, r4_zero;
   logic [W-1:0]        r4_spec_val;
   logic [3:0]          r4_spec_flags;
   logic [XW-1:0]       r4_exp;
   logic [E-1:0]        r4_norm;
   logic [TAG_W-1:0]    r4_tag;
   logic                w_rup, w_grs_any;
   logic [M:0]          w_mant_r;
   logic [XW-1:0]       w_exp5;
   logic [MAN_W-1:0]    w_frac5;
   logic [W-1:0]        w_sum5;
   logic [3:0]          w_flags5;

   always_comb begin
      w_grs_any = |r4_norm[2:0];
      w_rup     = r4_norm[2] & (r4_norm[1] | r4_norm[0] | r4_norm[3]);
      w_mant_r  = {1'b0, r4_norm[E-1:3]} + {{M{1'b0}}, w_rup};
      // A rounding carry leaves 1.000..0 one binade up.
      w_exp5    = r4_exp + {{(XW-1){1'b0}}, w_mant_r[M]};
      w_frac5   = w_mant_r[M] ? '0 : w_mant_r[MAN_W-1:0];

      w_sum5   = '0;
      w_flags5 = '0;
      if (r4_special) begin
         w_sum5   = r4_spec_val;
         w_flags5 = r4_spec_flags;
      end else if (r4_zero) begin
         w_sum5 = '0;
      end else if (r4_exp[XW-1] || r4_exp == '0) begin
         w_sum5 = {r4_sign, {(W-1){1'b0}}};
         w_flags5[FLAG_UNDERFLOW] = 1'b1;
         w_flags5[FLAG_INEXACT]   = 1'b1;
      end else if (w_exp5 >= EXP_ONES) begin
         w_sum5 = {r4_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
         w_flags5[FLAG_OVERFLOW] = 1'b1;
         w_flags5[FLAG_INEXACT]  = 1'b1;
      end else begin
         w_sum5 = {r4_sign, w_exp5[EXP_W-1:0], w_frac5};
         w_flags5[FLAG_INEXACT] = w_grs_any;
      end
   end

   logic w_unused_ok;
   assign w_unused_ok = ^{w_qnan_wide[FP_MAX_W-1:W], w_mant_r[MAN_W]};

   // ---------------- control and output registers ---------------------------
   logic r_v1, r_v2, r_v3, r_v4, r_out_valid;
   logic [W-1:0]     r_sum;
   logic [TAG_W-1:0] r_out_tag;
   logic [3:0]       r_flags;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_v1        <= 1'b0;
         r_v2        <= 1'b0;
         r_v3        <= 1'b0;
         r_v4        <= 1'b0;
         r_out_valid <= 1'b0;
         r_sum       <= '0;
         r_out_tag   <= '0;
         r_flags     <= '0;
      end else if (w_adv) begin
         r_v1        <= in_valid;
         r_v2        <= r_v1;
         r_v3        <= r_v2;
         r_v4        <= r_v3;
         r_out_valid <= r_v4;
         r_sum       <= w_sum5;
         r_out_tag   <= r4_tag;
         r_flags     <= w_flags5;
      end
   end

   assign out_valid = r_out_valid;
   assign sum       = r_sum;
   assign out_tag   = r_out_tag;
   assign flags     = r_flags;

   // Datapath registers carry no reset; the valid bits qualify them.
   always_ff @(posedge clk) begin
      if (w_adv) begin
         r1_special    <= w_special;
         r1_spec_val   <= w_spec_val;
         r1_spec_flags <= w_spec_flags;
         r1_sign       <= w_big_s;
         r1_sub        <= a[W-1] ^ b[W-1];
         r1_exp        <= w_big_e;
         r1_diff       <= w_big_e - w_sml_e;
         r1_ma         <= w_ma;
         r1_mb         <= w_mb;
         r1_tag        <= in_tag;

         r2_special    <= r1_special;
         r2_spec_val   <= r1_spec_val;
         r2_spec_flags <= r1_spec_flags;
         r2_sign       <= r1_sign;
         r2_sub        <= r1_sub;
         r2_exp        <= r1_exp;
         r2_ma         <= {r1_ma, 3'b000};
         r2_mb         <= w_b_al;
         r2_tag        <= r1_tag;

         r3_special    <= r2_special;
         r3_spec_val   <= r2_spec_val;
         r3_spec_flags <= r2_spec_flags;
         r3_sign       <= r2_sign;
         r3_exp        <= r2_exp;
         r3_mag        <= w_mag;
         r3_tag        <= r2_tag;

         r4_special    <= r3_special;
         r4_spec_val   <= r3_spec_val;
         r4_spec_flags <= r3_spec_flags;
         r4_sign       <= r3_sign;
         r4_exp        <= w_exp4;
         r4_norm       <= w_norm;
         r4_zero       <= (r3_mag == '0);  // exact cancellation gives +0
         r4_tag        <= r3_tag;
      end
   end

endmodule
